rv_decode_stage: RTL
====================

# rv_decode_stage

Registered RV32I decode stage with a valid/ready handshake on both sides, sitting between instruction fetch and the register-file/execute stage. It replaces the purely combinational decoder. It extends that decoder with:
- full opcode coverage: loads, stores, LUI, AUIPC
- immediate generation
- x0 write suppression
- pipeline flush
- an optional skid buffer, so fetch never sees a combinational ready path.

## Interface
Parameters:
- PC_W, 32, width of the carried program counter
- SKID, 1, 1 = two-entry skid buffer (registered in_ready); 0 = single register, in_ready = out_ready | ~out_valid

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  synchronous pipeline kill
- in_valid  in  1  fetch offers an instruction
- in_ready  out  1  stage can accept
- in_instr  in  32  instruction word
- in_pc  in  PC_W  address of in_instr
- out_valid  out  1  decoded bundle valid
- out_ready  in  1  execute accepts bundle
- out_pc  out  PC_W  carried PC
- out_rd, out_rs1, out_rs2  out  5 each  register indices
- out_imm  out  32  sign-extended immediate
- out_alu_ctrl  out  4  ALU or branch-compare code
- out_result_src  out  2  00 ALU, 01 memory, 10 PC+4, 11 immediate
- out_funct3  out  3  load/store width passthrough
- out_alu_src_imm  out  1  ALU B operand is out_imm
- out_reg_write, out_mem_read, out_mem_write  out  1 each
- out_branch, out_jal, out_jalr  out  1 each
- out_illegal  out  1  unrecognised encoding

## Operation
- The transfer rule is the same on both sides: a transfer occurs on a rising edge where valid & ready.

Decode is combinational on in_instr and registered on accept. Opcodes:
- 0110011 R
- 0010011 I-ALU
- 0000011 load
- 0100011 store
- 1100011 branch
- 1101111 JAL
- 1100111 JALR
- 0110111 LUI
- 0010111 AUIPC

ALU codes for R and I-ALU:
- ADD 0, SUB 1, AND 2, OR 3, XOR 4, SLL 5, SRL 6, SRA 7, SLTU 8, SLT 9
- SUB applies only to R-type with instr[30]=1. SRA is selected by instr[30] for both R and I shifts.
- Loads, stores, JALR and AUIPC use ADD. LUI uses ADD with out_result_src=11.

Branch compare codes (funct3 000/001/100/101/110/111):
- BEQ 0, BNE 1, BLT 2, BGE 3, BLTU 4, BGEU 5
- Branch funct3 010/011 is illegal.

Immediates:
- I, S, B, U, J formats, sign-extended from instr[31].
- B and J immediates have bit 0 = 0.
- U immediate is instr[31:12] followed by 12 zeros.

Register write and result source:
- out_reg_write = (R | I-ALU | load | JAL | JALR | LUI | AUIPC) & rd != 0.
- out_result_src = 01 for loads and 10 for JAL/JALR.

Skid buffer (SKID=1):
- Main register plus one skid entry.
- in_ready is registered and equals "skid entry empty".
- If out_ready is low while an input is accepted, the input lands in skid.
- When main drains, skid moves to main.
- Strict in-order delivery; no drop, no duplicate.

Flush:
- Clears main and skid valid bits.
- An input offered in the same cycle is discarded.
- Flush takes priority over accept and shift.

## Timing
- Latency: 1 cycle, accept at edge N gives out_valid at N+1.
- Throughput: 1 per cycle while out_ready=1.
- Reset: every out_* is 0, including out_valid and out_illegal. in_ready is 1 for SKID=1, and also 1 for SKID=0 (out_valid=0).
- Reset asserted mid-stream drops all held instructions immediately, asynchronously.
- While out_valid & ~out_ready, all out_* hold stable.
- Simultaneous drain and accept with skid empty: the new bundle goes to main; skid stays empty.
- Skid full and main draining: skid moves to main; in_ready rises the following cycle.

## Configuration
- RV_DECODE_ILLEGAL_EN defined:
  - Unknown opcode, branch funct3 010/011, or invalid R/shift funct7 sets out_illegal=1.
  - In that case out_reg_write, out_mem_read, out_mem_write, out_branch, out_jal and out_jalr are forced to 0.
- RV_DECODE_ILLEGAL_EN undefined:
  - out_illegal is tied to 0.
  - Unknown encodings decode as a NOP (all control flags 0, alu_ctrl 0).

## Test plan
- ADDI, 0x00500093 at pc 0x100, out_ready=1: next cycle out_valid=1, rd=1, rs1=0, imm=5, alu_ctrl=0, alu_src_imm=1, reg_write=1, out_pc=0x100.
- SUB 0x402081B3 then SRA 0x4020D1B3 back-to-back: alu_ctrl=1 then 7 on consecutive cycles, rd=3, reg_write=1.
- BEQ 0xFE208EE3: branch=1, alu_ctrl=0, imm=0xFFFFFFFC, reg_write=0. LUI 0x123452B7: imm=0x12345000, result_src=11, rd=5.
- Illegal 0x0000007F with RV_DECODE_ILLEGAL_EN: out_illegal=1, all write/memory/flow flags 0. ADDI x0 (0x00000013): reg_write=0.
- SKID=1, out_ready=0 for 3 cycles while in_valid streams I0, I1, I2: I0 and I1 accepted, then in_ready=0. After release, I0, I1, I2 are delivered in order, one per cycle.
- Flush with main and skid full and in_valid=1: next cycle out_valid=0 and in_ready=1; no flushed PC ever appears on the output.

Source files
------------

// File: rtl/rv_decode_stage.sv
// RV32I decode stage with valid/ready on both sides and an optional two-entry skid buffer.
// Define RV_DECODE_ILLEGAL_EN to report unrecognised encodings on out_illegal.
module rv_decode_stage #(
    parameter int unsigned PC_W = 32,
    parameter int unsigned SKID = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [PC_W-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [PC_W-1:0] out_pc,
    output logic [4:0]      out_rd,
    output logic [4:0]      out_rs1,
    output logic [4:0]      out_rs2,
    output logic [31:0]     out_imm,
    output logic [3:0]      out_alu_ctrl,
    output logic [1:0]      out_result_src,
    output logic [2:0]      out_funct3,
    output logic            out_alu_src_imm,
    output logic            out_reg_write,
    output logic            out_mem_read,
    output logic            out_mem_write,
    output logic            out_branch,
    output logic            out_jal,
    output logic            out_jalr,
    output logic            out_illegal
);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_SLL  = 4'd5;
    localparam logic [3:0] ALU_SRL  = 4'd6;
    localparam logic [3:0] ALU_SRA  = 4'd7;
    localparam logic [3:0] ALU_SLTU = 4'd8;
    localparam logic [3:0] ALU_SLT  = 4'd9;

    localparam logic [1:0] RES_ALU = 2'b00;
    localparam logic [1:0] RES_MEM = 2'b01;
    localparam logic [1:0] RES_PC4 = 2'b10;
    localparam logic [1:0] RES_IMM = 2'b11;

    typedef struct packed {
        logic [PC_W-1:0] pc;
        logic [4:0]      rd;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [31:0]     imm;
        logic [3:0]      alu_ctrl;
        logic [1:0]      result_src;
        logic [2:0]      funct3;
        logic            alu_src_imm;
        logic            reg_write;
        logic            mem_read;
        logic            mem_write;
        logic            branch;
        logic            jal;
        logic            jalr;
        logic            illegal;
    } bundle_t;

    // instr[30] picks SUB (R-type only) or SRA (R and I shifts)
    function automatic logic [3:0] alu_code(input logic [2:0] f3, input logic alt, input logic sub_ok);
        logic [3:0] code;
        case (f3)
            3'b000:  code = (alt && sub_ok) ? ALU_SUB : ALU_ADD;
            3'b001:  code = ALU_SLL;
            3'b010:  code = ALU_SLT;
            3'b011:  code = ALU_SLTU;
            3'b100:  code = ALU_XOR;
            3'b101:  code = alt ? ALU_SRA : ALU_SRL;
            3'b110:  code = ALU_OR;
            default: code = ALU_AND;
        endcase
        return code;
    endfunction

    logic [6:0]  opcode;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic        bad;
    bundle_t     dec;
    bundle_t     held;
    logic        held_v;

    assign opcode = in_instr[6:0];
    assign f3     = in_instr[14:12];
    assign f7     = in_instr[31:25];
    assign imm_i  = {{20{in_instr[31]}}, in_instr[31:20]};
    assign imm_s  = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
    assign imm_b  = {{19{in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};
    assign imm_u  = {in_instr[31:12], 12'h000};
    assign imm_j  = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0};

    // Combinational decode of the offered instruction
    always_comb begin
        dec        = '0;
        bad        = 1'b0;
        dec.pc     = in_pc;
        dec.rd     = in_instr[11:7];
        dec.rs1    = in_instr[19:15];
        dec.rs2    = in_instr[24:20];
        dec.funct3 = f3;
        case (opcode)
            OP_R: begin
                dec.alu_ctrl  = alu_code(f3, in_instr[30], 1'b1);
                dec.reg_write = 1'b1;
                bad = !((f7 == 7'h00) || ((f7 == 7'h20) && ((f3 == 3'b000) || (f3 == 3'b101))));
            end
            OP_I: begin
                dec.alu_ctrl    = alu_code(f3, in_instr[30], 1'b0);
                dec.imm         = imm_i;
                dec.alu_src_imm = 1'b1;
                dec.reg_write   = 1'b1;
                if (f3 == 3'b001)      bad = (f7 != 7'h00);
                else if (f3 == 3'b101) bad = !((f7 == 7'h00) || (f7 == 7'h20));
            end
            OP_LOAD: begin
                dec.imm         = imm_i;
                dec.alu_src_imm = 1'b1;
                dec.reg_write   = 1'b1;
                dec.mem_read    = 1'b1;
                dec.result_src  = RES_MEM;
            end
            OP_STORE: begin
                dec.imm         = imm_s;
                dec.alu_src_imm = 1'b1;
                dec.mem_write   = 1'b1;
            end
            OP_BRANCH: begin
                dec.imm    = imm_b;
                dec.branch = 1'b1;
                case (f3)
                    3'b000:  dec.alu_ctrl = 4'd0;
                    3'b001:  dec.alu_ctrl = 4'd1;
                    3'b100:  dec.alu_ctrl = 4'd2;
                    3'b101:  dec.alu_ctrl = 4'd3;
                    3'b110:  dec.alu_ctrl = 4'd4;
                    3'b111:  dec.alu_ctrl = 4'd5;
                    default: bad = 1'b1;
                endcase
            end
            OP_JAL: begin
                dec.imm        = imm_j;
                dec.jal        = 1'b1;
                dec.reg_write  = 1'b1;
                dec.result_src = RES_PC4;
            end
            OP_JALR: begin
                dec.imm         = imm_i;
                dec.jalr        = 1'b1;
                dec.reg_write   = 1'b1;
                dec.alu_src_imm = 1'b1;
                dec.result_src  = RES_PC4;
            end
            OP_LUI: begin
                dec.imm         = imm_u;
                dec.reg_write   = 1'b1;
                dec.alu_src_imm = 1'b1;
                dec.result_src  = RES_IMM;
            end
            OP_AUIPC: begin
                dec.imm         = imm_u;
                dec.reg_write   = 1'b1;
                dec.alu_src_imm = 1'b1;
                dec.result_src  = RES_ALU;
            end
            default: bad = 1'b1;
        endcase
        // Unrecognised encodings carry no side effects
        if (bad) begin
            dec.imm         = '0;
            dec.alu_ctrl    = ALU_ADD;
            dec.result_src  = RES_ALU;
            dec.alu_src_imm = 1'b0;
            dec.reg_write   = 1'b0;
            dec.mem_read    = 1'b0;
            dec.mem_write   = 1'b0;
            dec.branch      = 1'b0;
            dec.jal         = 1'b0;
            dec.jalr        = 1'b0;
        end
        dec.reg_write = dec.reg_write && (dec.rd != 5'd0);
`ifdef RV_DECODE_ILLEGAL_EN
        dec.illegal = bad;
`else
        dec.illegal = 1'b0;
`endif
    end

    generate
        if (SKID != 0) begin : g_skid
            bundle_t main_q, skid_q;
            logic    main_v, skid_v;

            // Main feeds the output; skid catches the word accepted while main stalls
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    main_v <= 1'b0;
                    skid_v <= 1'b0;
                    main_q <= '0;
                    skid_q <= '0;
                end else if (flush) begin
                    main_v <= 1'b0;
                    skid_v <= 1'b0;
                end else if (!main_v || out_ready) begin
                    if (skid_v) begin
                        main_q <= skid_q;
                        main_v <= 1'b1;
                        skid_v <= 1'b0;
                    end else begin
                        main_v <= in_valid;
                        if (in_valid) main_q <= dec;
                    end
                end else if (in_valid && !skid_v) begin
                    skid_q <= dec;
                    skid_v <= 1'b1;
                end
            end

            assign in_ready = ~skid_v;
            assign held     = main_q;
            assign held_v   = main_v;
        end else begin : g_single
            bundle_t main_q;
            logic    main_v;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    main_v <= 1'b0;
                    main_q <= '0;
                end else if (flush) begin
                    main_v <= 1'b0;
                end else if (in_ready) begin
                    main_v <= in_valid;
                    if (in_valid) main_q <= dec;
                end
            end

            assign in_ready = out_ready | ~main_v;
            assign held     = main_q;
            assign held_v   = main_v;
        end
    endgenerate

    assign out_valid       = held_v;
    assign out_pc          = held.pc;
    assign out_rd          = held.rd;
    assign out_rs1         = held.rs1;
    assign out_rs2         = held.rs2;
    assign out_imm         = held.imm;
    assign out_alu_ctrl    = held.alu_ctrl;
    assign out_result_src  = held.result_src;
    assign out_funct3      = held.funct3;
    assign out_alu_src_imm = held.alu_src_imm;
    assign out_reg_write   = held.reg_write;
    assign out_mem_read    = held.mem_read;
    assign out_mem_write   = held.mem_write;
    assign out_branch      = held.branch;
    assign out_jal         = held.jal;
    assign out_jalr        = held.jalr;
    assign out_illegal     = held.illegal;

endmodule
